// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the fetch port, data port and mainMem port of the
//             two-requester memory arbiter.
//             slave  = arbiter view, master = requesters + memory view.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch (read-only) requester
    logic                i_req;
    logic [0:ADDR_W-1]   i_addr;
    logic [1:0]          i_acc_size;
    logic                i_gnt;
    logic                i_rvalid;
    logic [0:DATA_W-1]   i_rdata;
    logic                i_done;

    // Data (load/store) requester
    logic                d_req;
    logic [0:ADDR_W-1]   d_addr;
    logic [1:0]          d_acc_size;
    logic                d_wren;
    logic [0:DATA_W-1]   d_wdata;
    logic                d_gnt;
    logic                d_wready;
    logic                d_rvalid;
    logic [0:DATA_W-1]   d_rdata;
    logic                d_done;

    // mainMem port
    logic [0:ADDR_W-1]   mem_addr;
    logic [0:DATA_W-1]   mem_data_in;
    logic [1:0]          mem_acc_size;
    logic                mem_wren;
    logic                mem_enable;
    logic [0:DATA_W-1]   mem_data_out;
    logic                mem_busy;

    modport slave (
        input  i_req, i_addr, i_acc_size,
        output i_gnt, i_rvalid, i_rdata, i_done,
        input  d_req, d_addr, d_acc_size, d_wren, d_wdata,
        output d_gnt, d_wready, d_rvalid, d_rdata, d_done,
        output mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable,
        input  mem_data_out, mem_busy
    );

    modport master (
        output i_req, i_addr, i_acc_size,
        input  i_gnt, i_rvalid, i_rdata, i_done,
        output d_req, d_addr, d_acc_size, d_wren, d_wdata,
        input  d_gnt, d_wready, d_rvalid, d_rdata, d_done,
        input  mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable,
        output mem_data_out, mem_busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter and burst sequencer between the fetch and
//             data requesters and the single mainMem port. Drives the
//             command, paces write beats and returns read beats.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    // RWAIT lasts READ_LAT-1 cycles; counter only needs to hold that value
    localparam int c_wait_w = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_load = c_wait_w'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_WBURST = 3'd2,
        S_RWAIT  = 3'd3,
        S_RBURST = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sel_d;      // current transfer belongs to data port
    logic                  r_last_d;     // most recent grant went to data port
    logic [0:ADDR_W-1]     r_addr;
    logic [1:0]            r_size;
    logic                  r_wren;
    logic [4:0]            r_beats;      // beats still to transfer
    logic [4:0]            w_beats_next;
    logic [c_wait_w-1:0]   r_wait;
    logic [c_wait_w-1:0]   w_wait_next;
    logic                  r_enable;

    logic                  w_pick_d;
    logic                  w_take;
    logic                  w_gnt;
    logic                  w_wready;
    logic                  w_rvalid;
    logic                  w_done;

    function automatic logic [4:0] beats_for(input logic [1:0] size);
        case (size)
            2'b00:   beats_for = 5'd1;
            2'b01:   beats_for = 5'd4;
            2'b10:   beats_for = 5'd8;
            default: beats_for = 5'd16;
        endcase
    endfunction

    // On a tie the port that did not win last time takes the grant
    assign w_pick_d = bus.d_req && (!bus.i_req || !r_last_d);
    assign w_take   = (r_state == S_IDLE) && (bus.i_req || bus.d_req);

    // State register, command latch and burst counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel_d  <= 1'b0;
            r_last_d <= 1'b0;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_wren   <= 1'b0;
            r_beats  <= 5'd0;
            r_wait   <= '0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_beats  <= w_beats_next;
            r_wait   <= w_wait_next;
            r_enable <= 1'b1;
            if (w_take) begin
                r_sel_d  <= w_pick_d;
                r_last_d <= w_pick_d;
                r_addr   <= w_pick_d ? bus.d_addr : bus.i_addr;
                r_size   <= w_pick_d ? bus.d_acc_size : bus.i_acc_size;
                r_wren   <= w_pick_d && bus.d_wren;
            end
        end
    end

    // Next-state and beat handshake decode; busy freezes every counter
    always_comb begin
        w_next_state = r_state;
        w_beats_next = r_beats;
        w_wait_next  = r_wait;
        w_gnt        = 1'b0;
        w_wready     = 1'b0;
        w_rvalid     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next_state = S_CMD;
                    w_beats_next = beats_for(w_pick_d ? bus.d_acc_size : bus.i_acc_size);
                end
            end
            S_CMD: begin
                w_gnt = 1'b1;
                if (r_wren) begin
                    // Command cycle doubles as write beat 0
                    w_wready     = !bus.mem_busy;
                    w_next_state = S_WBURST;
                    if (!bus.mem_busy) begin
                        if (r_beats == 5'd1) begin
                            w_done       = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_beats_next = r_beats - 5'd1;
                        end
                    end
                end else if (READ_LAT == 1) begin
                    w_next_state = S_RBURST;
                end else begin
                    w_next_state = S_RWAIT;
                    w_wait_next  = c_wait_load;
                end
            end
            S_WBURST: begin
                w_wready = !bus.mem_busy;
                if (!bus.mem_busy) begin
                    if (r_beats == 5'd1) begin
                        w_done       = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_beats_next = r_beats - 5'd1;
                    end
                end
            end
            S_RWAIT: begin
                if (!bus.mem_busy) begin
                    if (r_wait == c_wait_w'(1)) begin
                        w_next_state = S_RBURST;
                    end else begin
                        w_wait_next = r_wait - c_wait_w'(1);
                    end
                end
            end
            S_RBURST: begin
                w_rvalid = !bus.mem_busy;
                if (!bus.mem_busy) begin
                    if (r_beats == 5'd1) begin
                        w_done       = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_beats_next = r_beats - 5'd1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Steer handshakes to the port that owns the current transfer
    assign bus.i_gnt    = w_gnt && !r_sel_d;
    assign bus.d_gnt    = w_gnt &&  r_sel_d;
    assign bus.d_wready = w_wready;
    assign bus.i_rvalid = w_rvalid && !r_sel_d;
    assign bus.d_rvalid = w_rvalid &&  r_sel_d;
    assign bus.i_done   = w_done && !r_sel_d;
    assign bus.d_done   = w_done &&  r_sel_d;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_data_out : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_data_out : '0;

    // Command fields stay constant for the whole burst; mainMem walks addresses
    assign bus.mem_addr     = r_addr;
    assign bus.mem_acc_size = r_size;
    assign bus.mem_wren     = r_wren;
    assign bus.mem_enable   = r_enable;
    // Requester holds d_wdata until it sees d_wready, so stalls keep it stable
    assign bus.mem_data_in  = (r_wren && (r_state == S_CMD || r_state == S_WBURST))
                              ? bus.d_wdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter with a small
//             behavioural mainMem and a data-port write-beat source.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural mainMem: word-addressed, latches base on the grant cycle
    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;

    function automatic logic [7:0] widx(input logic [31:0] a);
        return a[9:2];
    endfunction

    always @(posedge clock) begin
        if (bus.i_gnt || bus.d_gnt) begin
            rd_ptr <= widx(bus.mem_addr);
            if (bus.d_wready) begin
                mem[widx(bus.mem_addr)] <= bus.mem_data_in;
                wr_ptr <= widx(bus.mem_addr) + 8'd1;
            end else begin
                wr_ptr <= widx(bus.mem_addr);
            end
        end else begin
            if (bus.d_wready) begin
                mem[wr_ptr] <= bus.mem_data_in;
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (bus.i_rvalid || bus.d_rvalid) rd_ptr <= rd_ptr + 8'd1;
        end
    end
    assign bus.mem_data_out = mem[rd_ptr];

    // Data-port write source: advances one word after each accepted beat
    logic [31:0] wtab [0:15];
    logic [3:0]  wbeat;
    logic [3:0]  wsel;
    always @(posedge clock) begin
        if (bus.d_gnt) wbeat <= bus.d_wready ? 4'd1 : 4'd0;
        else if (bus.d_wready) wbeat <= wbeat + 4'd1;
    end
    assign wsel        = bus.d_gnt ? 4'd0 : wbeat;
    assign bus.d_wdata = wtab[wsel];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        sample();
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.d_wready, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {bus.i_gnt, bus.d_gnt, bus.d_wready, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done});
        end
        n_checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h expected 0", bus.i_rdata, bus.d_rdata);
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_data_in} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got %h %h expected 0", bus.mem_addr, bus.mem_data_in);
        end
        n_checks++;
        if ({bus.mem_acc_size, bus.mem_wren, bus.mem_enable} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mem_ctrl: got %b expected 0000",
                     {bus.mem_acc_size, bus.mem_wren, bus.mem_enable});
        end
        step();
        reset = 1'b0;
        sample();
        n_checks++;
        if (bus.mem_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_before_edge: got %b expected 0", bus.mem_enable);
        end
        step();
        sample();
        n_checks++;
        if (bus.mem_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_after_release: got %b expected 1", bus.mem_enable);
        end
    endtask

    task automatic test_single_write_read();
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h80020000; bus.d_acc_size = 2'b00; bus.d_wren = 1'b1;
        wtab[0] = 32'h27BDFFF8;
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 1) bus.d_req = 1'b0;
            sample();
            n_checks++;
            if ({bus.d_gnt, bus.d_wready, bus.d_done} !== {3{c == 0}}) begin
                n_fail++;
                $display("FAIL single_write_hs c=%0d: got %b expected %b", c,
                         {bus.d_gnt, bus.d_wready, bus.d_done}, {3{c == 0}});
            end
            if (c == 0) begin
                n_checks++;
                if ({bus.mem_addr, bus.mem_data_in, bus.mem_wren} !== {32'h80020000, 32'h27BDFFF8, 1'b1}) begin
                    n_fail++;
                    $display("FAIL single_write_cmd: got %h %h %b expected 80020000 27bdfff8 1",
                             bus.mem_addr, bus.mem_data_in, bus.mem_wren);
                end
            end
        end
        step();
        bus.d_req = 1'b1; bus.d_wren = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 1) bus.d_req = 1'b0;
            sample();
            n_checks++;
            if ({bus.d_gnt, bus.d_rvalid, bus.d_done} !== {c == 0, c == 2, c == 2}) begin
                n_fail++;
                $display("FAIL single_read_hs c=%0d: got %b expected %b", c,
                         {bus.d_gnt, bus.d_rvalid, bus.d_done}, {c == 0, c == 2, c == 2});
            end
            if (c == 2) begin
                n_checks++;
                if (bus.d_rdata !== 32'h27BDFFF8) begin
                    n_fail++;
                    $display("FAIL single_read_data: got %h expected 27bdfff8", bus.d_rdata);
                end
            end
        end
    endtask

    task automatic test_burst_write_fetch_read();
        logic [31:0] words [0:3];
        words[0] = 32'h0BADF00D; words[1] = 32'hCAFEBABE;
        words[2] = 32'h12345678; words[3] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) wtab[i] = words[i];
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h80020004; bus.d_acc_size = 2'b01; bus.d_wren = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 1) bus.d_req = 1'b0;
            sample();
            n_checks++;
            if ({bus.d_gnt, bus.d_wready, bus.d_done} !== {c == 0, c < 4, c == 3}) begin
                n_fail++;
                $display("FAIL burst_write_hs c=%0d: got %b expected %b", c,
                         {bus.d_gnt, bus.d_wready, bus.d_done}, {c == 0, c < 4, c == 3});
            end
            if (c < 4) begin
                n_checks++;
                if ({bus.mem_addr, bus.mem_data_in} !== {32'h80020004, words[c]}) begin
                    n_fail++;
                    $display("FAIL burst_write_bus c=%0d: got %h %h expected 80020004 %h", c,
                             bus.mem_addr, bus.mem_data_in, words[c]);
                end
            end
        end
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h80020004; bus.i_acc_size = 2'b01;
        for (int c = 0; c < 7; c++) begin
            step();
            if (c == 1) bus.i_req = 1'b0;
            sample();
            n_checks++;
            if ({bus.i_gnt, bus.i_rvalid, bus.i_done, bus.d_rvalid} !== {c == 0, c >= 2 && c <= 5, c == 5, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_read_hs c=%0d: got %b expected %b", c,
                         {bus.i_gnt, bus.i_rvalid, bus.i_done, bus.d_rvalid},
                         {c == 0, c >= 2 && c <= 5, c == 5, 1'b0});
            end
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (bus.i_rdata !== words[c-2]) begin
                    n_fail++;
                    $display("FAIL fetch_read_data c=%0d: got %h expected %h", c, bus.i_rdata, words[c-2]);
                end
            end
        end
    endtask

    task automatic test_tie();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h80020000; bus.i_acc_size = 2'b00;
        bus.d_req = 1'b1; bus.d_addr = 32'h80020000; bus.d_acc_size = 2'b00; bus.d_wren = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 13) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
            sample();
            n_checks++;
            if ({bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid} !==
                {c == 0 || c == 8, c == 4 || c == 12, c == 2 || c == 10, c == 6 || c == 14}) begin
                n_fail++;
                $display("FAIL tie_alternate c=%0d: got %b expected %b", c,
                         {bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid},
                         {c == 0 || c == 8, c == 4 || c == 12, c == 2 || c == 10, c == 6 || c == 14});
            end
        end
    endtask

    task automatic test_stall();
        int beats = 0;
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h80020000; bus.d_acc_size = 2'b11; bus.d_wren = 1'b0;
        for (int c = 0; c < 23; c++) begin
            step();
            if (c == 1)  bus.d_req    = 1'b0;
            if (c == 7)  bus.mem_busy = 1'b1;
            if (c == 10) bus.mem_busy = 1'b0;
            sample();
            if (bus.d_rvalid === 1'b1) beats++;
            n_checks++;
            if ({bus.d_rvalid, bus.d_done} !== {(c >= 2 && c <= 6) || (c >= 10 && c <= 20), c == 20}) begin
                n_fail++;
                $display("FAIL stall_beat c=%0d: got %b expected %b", c, {bus.d_rvalid, bus.d_done},
                         {(c >= 2 && c <= 6) || (c >= 10 && c <= 20), c == 20});
            end
            if (c == 8) begin
                n_checks++;
                if ({bus.mem_addr, bus.mem_acc_size, bus.mem_wren} !== {32'h80020000, 2'b11, 1'b0}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h %b %b expected 80020000 11 0",
                             bus.mem_addr, bus.mem_acc_size, bus.mem_wren);
                end
            end
        end
        n_checks++;
        if (beats != 16) begin
            n_fail++;
            $display("FAIL stall_beat_count: got %0d expected 16", beats);
        end
    endtask

    task automatic test_reset_mid_burst();
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h80020040; bus.d_acc_size = 2'b10; bus.d_wren = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            if (c == 1) bus.d_req = 1'b0;
            if (c == 3) reset = 1'b1;
            if (c == 4) begin
                reset = 1'b0;
                bus.i_req = 1'b1; bus.i_addr = 32'h80020000; bus.i_acc_size = 2'b00;
            end
            if (c == 6) bus.i_req = 1'b0;
            sample();
            n_checks++;
            if ({bus.d_wready, bus.d_done, bus.i_gnt, bus.i_done} !== {c <= 3, 1'b0, c == 5, c == 7}) begin
                n_fail++;
                $display("FAIL mid_reset_hs c=%0d: got %b expected %b", c,
                         {bus.d_wready, bus.d_done, bus.i_gnt, bus.i_done}, {c <= 3, 1'b0, c == 5, c == 7});
            end
            if (c == 4) begin
                n_checks++;
                if ({bus.mem_addr, bus.mem_data_in, bus.mem_acc_size, bus.mem_wren, bus.mem_enable, bus.d_gnt} !== 70'h0) begin
                    n_fail++;
                    $display("FAIL mid_reset_outputs: got %h %h %b %b %b %b expected all 0",
                             bus.mem_addr, bus.mem_data_in, bus.mem_acc_size, bus.mem_wren,
                             bus.mem_enable, bus.d_gnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h80020004; bus.d_acc_size = 2'b00; bus.d_wren = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (c == 5) bus.d_req = 1'b0;
            sample();
            n_checks++;
            if ({bus.d_gnt, bus.d_done} !== {c == 0 || c == 4, c == 2 || c == 6}) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d: got %b expected %b", c,
                         {bus.d_gnt, bus.d_done}, {c == 0 || c == 4, c == 2 || c == 6});
            end
            if (c == 2 || c == 6) begin
                n_checks++;
                if (bus.d_rdata !== 32'h0BADF00D) begin
                    n_fail++;
                    $display("FAIL back_to_back_data c=%0d: got %h expected 0badf00d", c, bus.d_rdata);
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.i_acc_size = 2'b00;
        bus.d_req      = 1'b0;
        bus.d_addr     = '0;
        bus.d_acc_size = 2'b00;
        bus.d_wren     = 1'b0;
        bus.mem_busy   = 1'b0;
        for (int i = 0; i < 16; i++) wtab[i] = 32'h0;

        test_reset();
        test_single_write_read();
        test_burst_write_fetch_read();
        test_tie();
        test_stall();
        test_reset_mid_burst();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
